pwm_actuator_driver: RTL and testbench

- Actuator-side end of the control loop. Takes the 8-bit control word produced by the loop controller and turns it into a fixed-frequency PWM drive signal.
- Duty updates are double-buffered and applied only at period boundaries.
- Duty changes are slew-limited per period.
- Provides a half-bridge output pair (pwm_hi, pwm_lo) and a period_start strobe that the loop uses to pace its sampling.

---
 rtl/pwm_actuator_driver_if.sv | 31 +++
 rtl/pwm_actuator_driver.sv | 160 ++++++++++++++++
 tb/tb_pwm_actuator_driver.sv | 218 +++++++++++++++++++++
 3 files changed

// File: rtl/pwm_actuator_driver_if.sv
// rtl/pwm_actuator_driver_if.sv - control and drive signal bundle for pwm_actuator_driver
//
// Groups the loop-side control inputs and the PWM drive outputs so the
// controller and the driver connect through one port.
//   en            run enable (low = outputs off, soft restart)
//   duty_in       requested duty word, 0..255
//   duty_valid    one-clk strobe, capture duty_in
//   pwm_hi        high-side drive
//   pwm_lo        low-side drive
//   period_start  one-clk pulse at each PWM period start
//   duty_applied  duty currently in force
// Modports: master = loop controller side, slave = driver side.
interface pwm_actuator_driver_if;
    logic       en;
    logic [7:0] duty_in;
    logic       duty_valid;
    logic       pwm_hi;
    logic       pwm_lo;
    logic       period_start;
    logic [7:0] duty_applied;

    modport master (
        output en, duty_in, duty_valid,
        input  pwm_hi, pwm_lo, period_start, duty_applied
    );

    modport slave (
        input  en, duty_in, duty_valid,
        output pwm_hi, pwm_lo, period_start, duty_applied
    );
endinterface

// File: rtl/pwm_actuator_driver.sv
// rtl/pwm_actuator_driver.sv - fixed-frequency slew-limited PWM half-bridge driver
//
// Turns the 8-bit loop control word into a 256-tick PWM waveform. Duty is
// double-buffered (target register) and only moved into force at the period
// wrap, by at most SLEW counts per period.
//
// Ports:
//   clk    system clock
//   rst_n  asynchronous active-low reset
//   bus    pwm_actuator_driver_if.slave (en, duty_in, duty_valid in;
//          pwm_hi, pwm_lo, period_start, duty_applied out)
//
// Parameters:
//   PRESCALE  clk cycles per PWM counter tick, 1..65535
//   SLEW      max duty change per period, 0 = apply target directly
//   DEADTIME  dead band in clks, 1..255, only with PWM_ACTUATOR_DEADTIME_EN
//
// Optional feature macro: PWM_ACTUATOR_DEADTIME_EN (dead-band generator on
// the half-bridge outputs). Without it pwm_hi/pwm_lo are registered raw/~raw.
module pwm_actuator_driver #(
    parameter int PRESCALE = 1,
    parameter int SLEW     = 8,
    parameter int DEADTIME = 4
) (
    input  logic clk,
    input  logic rst_n,
    pwm_actuator_driver_if.slave bus
);

    localparam logic [15:0] PRE_LAST  = 16'(PRESCALE - 1);
    localparam int          SLEW_SAT  = (SLEW > 255) ? 255 : SLEW;
    localparam logic [7:0]  SLEW_STEP = 8'(SLEW_SAT);

    logic [15:0] prescaler;
    logic [7:0]  cnt;
    logic [7:0]  target;
    logic [7:0]  applied;
    logic [7:0]  applied_next;
    logic        period_start_q;
    logic        restart_pend;
    logic        pwm_hi_q;
    logic        pwm_lo_q;
    logic        tick;
    logic        wrap;
    logic        raw;

    assign tick = (prescaler == PRE_LAST);
    assign wrap = tick && (cnt == 8'hFF);
    assign raw  = (cnt < applied);

    // Slew step toward target; the min() is folded into the compare so the
    // result never passes the target and never wraps.
    always_comb begin
        applied_next = applied;
        if (SLEW == 0) begin
            applied_next = target;
        end else if (target > applied) begin
            if ((target - applied) > SLEW_STEP)
                applied_next = applied + SLEW_STEP;
            else
                applied_next = target;
        end else if (target < applied) begin
            if ((applied - target) > SLEW_STEP)
                applied_next = applied - SLEW_STEP;
            else
                applied_next = target;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescaler      <= '0;
            cnt            <= '0;
            target         <= '0;
            applied        <= '0;
            period_start_q <= 1'b0;
            restart_pend   <= 1'b1;
        end else begin
            // Target is written regardless of en; a write coincident with the
            // wrap is seen only at the next wrap because applied_next uses the
            // registered (old) target.
            if (bus.duty_valid)
                target <= bus.duty_in;

            if (!bus.en) begin
                prescaler      <= '0;
                cnt            <= '0;
                applied        <= '0;
                period_start_q <= 1'b0;
                restart_pend   <= 1'b1;
            end else begin
                prescaler      <= tick ? '0 : prescaler + 16'd1;
                // restart_pend marks the first tick after enable so the loop
                // gets a pacing pulse without waiting a whole period.
                period_start_q <= wrap || (tick && restart_pend);
                if (tick) begin
                    cnt          <= cnt + 8'd1;
                    restart_pend <= 1'b0;
                    if (cnt == 8'hFF)
                        applied <= applied_next;
                end
            end
        end
    end

`ifdef PWM_ACTUATOR_DEADTIME_EN
    localparam logic [7:0] DT_LAST = 8'(DEADTIME);

    logic       raw_prev;
    logic [7:0] dt_cnt;

    // Any raw edge drops both outputs and restarts the dead-band count; the
    // new side is driven only once raw has held for DEADTIME clks, so short
    // pulses are swallowed and the pair can never overlap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
            raw_prev <= 1'b0;
            dt_cnt   <= '0;
        end else if (!bus.en) begin
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
            raw_prev <= 1'b0;
            dt_cnt   <= '0;
        end else if (raw != raw_prev) begin
            raw_prev <= raw;
            dt_cnt   <= 8'd1;
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
        end else if (dt_cnt < DT_LAST) begin
            dt_cnt   <= dt_cnt + 8'd1;
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
        end else begin
            pwm_hi_q <= raw;
            pwm_lo_q <= ~raw;
        end
    end
`else
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
        end else if (!bus.en) begin
            pwm_hi_q <= 1'b0;
            pwm_lo_q <= 1'b0;
        end else begin
            pwm_hi_q <= raw;
            pwm_lo_q <= ~raw;
        end
    end
`endif

    assign bus.pwm_hi       = pwm_hi_q;
    assign bus.pwm_lo       = pwm_lo_q;
    assign bus.period_start = period_start_q;
    assign bus.duty_applied = applied;

endmodule

// File: tb/tb_pwm_actuator_driver.sv
// tb/tb_pwm_actuator_driver.sv - directed self-checking bench for pwm_actuator_driver
module tb_pwm_actuator_driver;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    pwm_actuator_driver_if b0 ();
    pwm_actuator_driver_if b1 ();
    pwm_actuator_driver_if b2 ();

    pwm_actuator_driver #(.PRESCALE(1), .SLEW(0), .DEADTIME(4)) u0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    pwm_actuator_driver #(.PRESCALE(1), .SLEW(8), .DEADTIME(4)) u1 (.clk(clk), .rst_n(rst_n), .bus(b1));
    pwm_actuator_driver #(.PRESCALE(3), .SLEW(8), .DEADTIME(4)) u2 (.clk(clk), .rst_n(rst_n), .bus(b2));

`ifdef PWM_ACTUATOR_DEADTIME_EN
    localparam int HI64 = 60,  LO64 = 188;
    localparam int HI255 = 251, LO255 = 0;
`else
    localparam int HI64 = 64,  LO64 = 192;
    localparam int HI255 = 255, LO255 = 1;
`endif

    int   n_checks  = 0;
    int   n_fail    = 0;
    int   both_high = 0;
    int   idle_act  = 0;
    logic idle_mon  = 1'b0;

    task automatic check_eq(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if ((b0.pwm_hi && b0.pwm_lo) || (b1.pwm_hi && b1.pwm_lo) || (b2.pwm_hi && b2.pwm_lo))
            both_high++;
        if (idle_mon && (b0.pwm_hi || b0.pwm_lo || b0.period_start ||
                         b1.pwm_hi || b1.pwm_lo || b1.period_start ||
                         b2.pwm_hi || b2.pwm_lo || b2.period_start))
            idle_act++;
    end

    function automatic int ps_of(input int i);
        case (i)
            0:       return int'(b0.period_start);
            1:       return int'(b1.period_start);
            default: return int'(b2.period_start);
        endcase
    endfunction

    function automatic int ap_of(input int i);
        case (i)
            0:       return int'(b0.duty_applied);
            1:       return int'(b1.duty_applied);
            default: return int'(b2.duty_applied);
        endcase
    endfunction

    task automatic strobe(input int i, input logic [7:0] d);
        case (i)
            0:       begin b0.duty_in = d; b0.duty_valid = 1'b1; end
            1:       begin b1.duty_in = d; b1.duty_valid = 1'b1; end
            default: begin b2.duty_in = d; b2.duty_valid = 1'b1; end
        endcase
        @(negedge clk);
        b0.duty_valid = 1'b0;
        b1.duty_valid = 1'b0;
        b2.duty_valid = 1'b0;
    endtask

    task automatic wait_ps(input int i, input string tag, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (ps_of(i) == 0 && n < 3000);
        check_eq({tag, " period_start seen"}, ps_of(i), 1);
    endtask

    // Called on a period_start sample; counts drive over one 256-clk period
    // and expects the next period_start exactly 256 clks later.
    task automatic measure0(input string tag, output int hi, output int lo);
        hi = 0;
        lo = 0;
        for (int k = 0; k < 256; k++) begin
            hi += int'(b0.pwm_hi);
            lo += int'(b0.pwm_lo);
            @(negedge clk);
        end
        check_eq({tag, " next period_start"}, int'(b0.period_start), 1);
    endtask

    int n, hi, lo;
    int slew_up[3] = '{8, 16, 20};
    int slew_dn[2] = '{12, 5};

    initial begin
        b0.en = 1'b0; b0.duty_in = '0; b0.duty_valid = 1'b0;
        b1.en = 1'b0; b1.duty_in = '0; b1.duty_valid = 1'b0;
        b2.en = 1'b0; b2.duty_in = '0; b2.duty_valid = 1'b0;

        repeat (3) @(negedge clk);
        check_eq("reset pwm_hi", int'(b0.pwm_hi), 0);
        check_eq("reset pwm_lo", int'(b0.pwm_lo), 0);
        check_eq("reset period_start", int'(b0.period_start), 0);
        check_eq("reset duty_applied", int'(b0.duty_applied), 0);

        rst_n    = 1'b1;
        idle_mon = 1'b1;
        repeat (300) @(negedge clk);
        idle_mon = 1'b0;
        check_eq("idle with en=0 activity", idle_act, 0);

        // Basic duty, PRESCALE=1, SLEW=0
        strobe(0, 8'd64);
        b0.en = 1'b1;
        wait_ps(0, "basic en", n);
        check_eq("basic applied first period", ap_of(0), 0);
        wait_ps(0, "basic wrap1", n);
        check_eq("basic applied after wrap", ap_of(0), 64);
        wait_ps(0, "basic wrap2", n);
        check_eq("basic period length", n, 256);
        measure0("duty64", hi, lo);
        check_eq("duty64 hi clks", hi, HI64);
        check_eq("duty64 lo clks", lo, LO64);

        strobe(0, 8'd255);
        wait_ps(0, "d255 w1", n);
        wait_ps(0, "d255 w2", n);
        check_eq("d255 applied", ap_of(0), 255);
        measure0("duty255", hi, lo);
        check_eq("duty255 hi clks", hi, HI255);
        check_eq("duty255 lo clks", lo, LO255);

        strobe(0, 8'd0);
        wait_ps(0, "d0 w1", n);
        wait_ps(0, "d0 w2", n);
        measure0("duty0", hi, lo);
        check_eq("duty0 hi clks", hi, 0);
        check_eq("duty0 lo clks", lo, 256);

        // Now on a cnt==0 sample: step to cnt==255 and strobe across the wrap.
        repeat (255) @(negedge clk);
        b0.duty_in    = 8'd100;
        b0.duty_valid = 1'b1;
        @(negedge clk);
        b0.duty_valid = 1'b0;
        check_eq("coincident period_start", int'(b0.period_start), 1);
        check_eq("coincident uses old target", ap_of(0), 0);
        wait_ps(0, "coincident next", n);
        check_eq("coincident next period len", n, 256);
        check_eq("coincident applied later", ap_of(0), 100);

        // Slew, SLEW=8
        strobe(1, 8'd20);
        b1.en = 1'b1;
        wait_ps(1, "slew en", n);
        check_eq("slew start applied", ap_of(1), 0);
        for (int k = 0; k < 3; k++) begin
            wait_ps(1, "slew up", n);
            check_eq($sformatf("slew up step %0d", k), ap_of(1), slew_up[k]);
        end
        strobe(1, 8'd5);
        for (int k = 0; k < 2; k++) begin
            wait_ps(1, "slew dn", n);
            check_eq($sformatf("slew down step %0d", k), ap_of(1), slew_dn[k]);
        end

        // Enable / prescale, PRESCALE=3
        strobe(2, 8'd128);
        b2.en = 1'b1;
        wait_ps(2, "pre en", n);
        wait_ps(2, "pre w1", n);
        check_eq("pre applied w1", ap_of(2), 8);
        wait_ps(2, "pre w2", n);
        check_eq("pre period length", n, 768);
        check_eq("pre applied w2", ap_of(2), 16);
        repeat (100) @(negedge clk);
        check_eq("pre pwm_lo before drop", int'(b2.pwm_lo), 1);
        b2.en = 1'b0;
        @(negedge clk);
        check_eq("en drop pwm_hi", int'(b2.pwm_hi), 0);
        check_eq("en drop pwm_lo", int'(b2.pwm_lo), 0);
        check_eq("en drop applied", ap_of(2), 0);
        check_eq("en drop period_start", ps_of(2), 0);
        repeat (5) @(negedge clk);
        b2.en = 1'b1;
        wait_ps(2, "re-en", n);
        check_eq("re-en applied", ap_of(2), 0);
        wait_ps(2, "re-en w1", n);
        check_eq("re-en soft start", ap_of(2), 8);
        wait_ps(2, "re-en w2", n);
        check_eq("re-en period length", n, 768);
        check_eq("re-en target kept", ap_of(2), 16);

        // Async reset mid-period with duty 128
        strobe(0, 8'd128);
        wait_ps(0, "rst w1", n);
        wait_ps(0, "rst w2", n);
        repeat (50) @(negedge clk);
        check_eq("pre-reset pwm_hi", int'(b0.pwm_hi), 1);
        #2 rst_n = 1'b0;
        #1;
        check_eq("async reset pwm_hi", int'(b0.pwm_hi), 0);
        check_eq("async reset pwm_lo", int'(b0.pwm_lo), 0);
        check_eq("async reset applied", ap_of(0), 0);

        check_eq("never both high", both_high, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
